// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the modulo counter family.
package counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the count enable by PRESCALE; tick fires on the last enabled clock of each period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic ck,
  input  logic res,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_pass
    logic unused_s;
    assign unused_s = &{1'b0, ck, res, clr};
    assign tick     = en;
  end else begin : g_div
    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST_V = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE_V  = PW'(1);
    logic [PW-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST_V);

    // Phase counter: clears on load, advances only on enabled clocks.
    always_ff @(posedge ck or negedge res) begin
      if (!res) begin
        cnt_r <= {PW{1'b0}};
      end else if (clr) begin
        cnt_r <= {PW{1'b0}};
      end else if (en) begin
        cnt_r <= (cnt_r == LAST_V) ? {PW{1'b0}} : cnt_r + ONE_V;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/counter_unit_mod.sv
// Up/down modulo-N counter with load, prescaled enable, wrap/saturate and cascade outputs.
module counter_unit_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             ck,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || PRESCALE < 1) begin : g_bad_param
    $fatal(1, "counter_unit_mod: illegal MODULUS/PRESCALE for WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  // One extra bit so the clamp compare stays meaningful when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_V  = (WIDTH + 1)'(MODULUS);

  logic             tick_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .ck   (ck),
    .res  (res),
    .en   (en),
    .clr  (ld),
    .tick (tick_s)
  );

  // Next count and overflow flag; load beats tick, and a boundary tick always flags ovf.
  always_comb begin
    q_nxt_s   = q_r;
    ovf_nxt_s = 1'b0;
    if (ld) begin
      q_nxt_s = ({1'b0, d} >= MOD_V) ? MAX_V : d;
    end else if (tick_s) begin
      if (up == CNT_UP) begin
        if (q_r == MAX_V) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = (sat == MODE_SAT) ? q_r : ZERO_V;
        end else begin
          q_nxt_s = q_r + ONE_V;
        end
      end else begin
        if (q_r == ZERO_V) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = (sat == MODE_SAT) ? q_r : MAX_V;
        end else begin
          q_nxt_s = q_r - ONE_V;
        end
      end
    end else begin
      q_nxt_s   = q_r;
      ovf_nxt_s = 1'b0;
    end
  end

  // Count and overflow registers.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      q_r   <= ZERO_V;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign tc  = (up == CNT_UP) ? (q_r == MAX_V) : (q_r == ZERO_V);
  assign q   = q_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_counter_unit_mod.sv
// Self-checking bench: directed and random stimulus against an arithmetic counter model.
module tb_counter_unit_mod;

  logic ck;
  logic res;

  logic       m_en, m_up, m_ld, m_sat;
  logic [3:0] m_d, m_q;
  logic       m_tc, m_ovf;

  logic       p_en, p_up, p_ld, p_sat;
  logic [3:0] p_d, p_q;
  logic       p_tc, p_ovf;

  logic       c_en, c_up, c_ld, c_sat;
  logic [3:0] c_d, cu_q, ct_q;
  logic       cu_tc, cu_ovf, ct_tc, ct_ovf, c_ten_en;

  int n_checks;
  int n_pass;
  int mq, mph, movf;
  int pq, pph, povf;
  int uq, uph, uovf;
  int tq, tph, tovf;
  int ten_ovf_seen;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  assign c_ten_en = c_en & cu_tc;

  counter_unit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_main (
    .ck(ck), .res(res), .en(m_en), .up(m_up), .ld(m_ld), .d(m_d), .sat(m_sat),
    .q(m_q), .tc(m_tc), .ovf(m_ovf));

  counter_unit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_presc3 (
    .ck(ck), .res(res), .en(p_en), .up(p_up), .ld(p_ld), .d(p_d), .sat(p_sat),
    .q(p_q), .tc(p_tc), .ovf(p_ovf));

  counter_unit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_units (
    .ck(ck), .res(res), .en(c_en), .up(c_up), .ld(c_ld), .d(c_d), .sat(c_sat),
    .q(cu_q), .tc(cu_tc), .ovf(cu_ovf));

  counter_unit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_tens (
    .ck(ck), .res(res), .en(c_ten_en), .up(c_up), .ld(c_ld), .d(c_d), .sat(c_sat),
    .q(ct_q), .tc(ct_tc), .ovf(ct_ovf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int tc_model(input int m, input logic up, input int q);
    return (up ? (q == m - 1) : (q == 0)) ? 1 : 0;
  endfunction

  // One clock of the counter rules, written directly from the behavioural description.
  task automatic model_step(input int m, input int p, input logic en, input logic up,
                            input logic ld, input logic sat, input logic [3:0] d,
                            inout int q, inout int ph, inout int ovf);
    int  dd, nq;
    logic tick;
    dd   = int'(d);
    tick = en && (ph == p - 1);
    if (ld) begin
      q   = (dd >= m) ? m - 1 : dd;
      ph  = 0;
      ovf = 0;
    end else begin
      if (en) ph = tick ? 0 : ph + 1;
      ovf = 0;
      if (tick) begin
        nq = up ? q + 1 : q - 1;
        if (nq < 0 || nq >= m) begin
          ovf = 1;
          if (!sat) q = up ? 0 : m - 1;
        end else begin
          q = nq;
        end
      end
    end
  endtask

  task automatic model_reset();
    mq = 0; mph = 0; movf = 0;
    pq = 0; pph = 0; povf = 0;
    uq = 0; uph = 0; uovf = 0;
    tq = 0; tph = 0; tovf = 0;
  endtask

  task automatic check_all();
    check("main_q",   32'(m_q),   mq);
    check("main_ovf", 32'(m_ovf), movf);
    check("main_tc",  32'(m_tc),  tc_model(10, m_up, mq));
    check("p3_q",     32'(p_q),   pq);
    check("p3_ovf",   32'(p_ovf), povf);
    check("p3_tc",    32'(p_tc),  tc_model(10, p_up, pq));
    check("units_q",  32'(cu_q),  uq);
    check("units_ovf",32'(cu_ovf),uovf);
    check("tens_q",   32'(ct_q),  tq);
    check("tens_ovf", 32'(ct_ovf),tovf);
    check("tens_tc",  32'(ct_tc), tc_model(10, c_up, tq));
  endtask

  // Advance one clock; inputs are held from just after the previous edge.
  task automatic cycle();
    logic ten_en_m;
    ten_en_m = c_en && (tc_model(10, c_up, uq) == 1);
    @(posedge ck);
    model_step(10, 1, m_en, m_up, m_ld, m_sat, m_d, mq, mph, movf);
    model_step(10, 3, p_en, p_up, p_ld, p_sat, p_d, pq, pph, povf);
    model_step(10, 1, c_en, c_up, c_ld, c_sat, c_d, uq, uph, uovf);
    model_step(10, 1, ten_en_m, c_up, c_ld, c_sat, c_d, tq, tph, tovf);
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    res = 1'b0;
    m_en = 1'b0; m_up = 1'b0; m_ld = 1'b0; m_sat = 1'b0; m_d = 4'd0;
    p_en = 1'b0; p_up = 1'b1; p_ld = 1'b0; p_sat = 1'b0; p_d = 4'd0;
    c_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_sat = 1'b0; c_d = 4'd0;
    model_reset();

    // Reset state, including tc following up combinationally.
    #12;
    check("rst_q",     32'(m_q),   32'd0);
    check("rst_ovf",   32'(m_ovf), 32'd0);
    check("rst_tc_dn", 32'(m_tc),  32'd1);
    m_up = 1'b1;
    #1;
    check("rst_tc_up", 32'(m_tc),  32'd0);
    res = 1'b1;

    // Wrap counting up through 9 -> 0, prescaled instance running alongside.
    m_en = 1'b1; m_sat = 1'b0; p_en = 1'b1;
    repeat (12) cycle();
    check("up_end_q", 32'(m_q), 32'd2);

    // Prescaled instance: drop enable for two clocks mid-period.
    p_en = 1'b0;
    repeat (2) cycle();
    p_en = 1'b1;
    repeat (4) cycle();

    // Count down from 0 -> 9, 8, 7.
    m_ld = 1'b1; m_d = 4'd0;
    cycle();
    m_ld = 1'b0; m_up = 1'b0;
    #1;
    check("dn_tc_at0", 32'(m_tc), 32'd1);
    repeat (3) cycle();
    check("dn_end_q", 32'(m_q), 32'd7);

    // Asynchronous reset asserted between edges while q=7.
    #3;
    res = 1'b0;
    #1;
    model_reset();
    check("arst_q",   32'(m_q),   32'd0);
    check("arst_ovf", 32'(m_ovf), 32'd0);
    check("arst_pq",  32'(p_q),   32'd0);
    @(posedge ck);
    #1;
    res = 1'b1;
    repeat (4) cycle();

    // Saturate at 9, three extra ticks, then one tick down.
    m_up = 1'b1; m_sat = 1'b1; m_ld = 1'b1; m_d = 4'd6;
    cycle();
    m_ld = 1'b0;
    repeat (6) cycle();
    check("sat_hold_q",   32'(m_q),   32'd9);
    check("sat_hold_ovf", 32'(m_ovf), 32'd1);
    m_up = 1'b0;
    cycle();
    check("sat_dn_q", 32'(m_q), 32'd8);

    // Load beats a simultaneous tick; out-of-range load clamps.
    m_up = 1'b1; m_sat = 1'b0;
    m_ld = 1'b1; m_d = 4'd4;
    cycle();
    check("ld4_q", 32'(m_q), 32'd4);
    m_d = 4'd13;
    cycle();
    check("ld13_q", 32'(m_q), 32'd9);
    m_d = 4'd15;
    cycle();
    m_ld = 1'b0;
    cycle();

    // Cascaded units/tens count 00 -> 99 -> 00.
    c_en = 1'b1; c_up = 1'b1;
    ten_ovf_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (ct_ovf) ten_ovf_seen++;
    end
    check("casc_tens_ovf_pulses", 32'(ten_ovf_seen), 32'd1);
    check("casc_end", 32'({ct_q, cu_q}), 32'd0);

    // Random traffic on every instance.
    for (int i = 0; i < 400; i++) begin
      m_en  = 1'($urandom_range(0, 1));
      m_up  = 1'($urandom_range(0, 1));
      m_sat = 1'($urandom_range(0, 1));
      m_ld  = ($urandom_range(0, 7) == 0);
      m_d   = 4'($urandom_range(0, 15));
      p_en  = ($urandom_range(0, 3) != 0);
      p_up  = 1'($urandom_range(0, 1));
      p_sat = 1'($urandom_range(0, 1));
      p_ld  = ($urandom_range(0, 9) == 0);
      p_d   = 4'($urandom_range(0, 15));
      c_en  = ($urandom_range(0, 3) != 0);
      c_up  = ($urandom_range(0, 4) != 0);
      c_sat = ($urandom_range(0, 5) == 0);
      c_ld  = ($urandom_range(0, 19) == 0);
      c_d   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_unit_mod.md
Name: counter_unit_mod

Overview:
- Parametrised successor to the 4-bit free-running counter: up/down modulo-N counter with synchronous load, count enable, optional prescaler, and wrap/saturate mode.
- Provides a combinational terminal-count output (tc) and a registered overflow pulse (ovf) so several instances can be cascaded, e.g. into BCD digit chains or timer stages.
- Sits beside the existing counter in timing and display logic.

Parameters:
- WIDTH, 4, bit width of q and d.
- MODULUS, 16, count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 1, number of enabled clocks per count step. Legal range: >= 1. A value of 1 means no prescaling.

Ports:
- ck  in  1  clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- en  in  1  count enable, feeds the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- ld  in  1  synchronous load strobe.
- d  in  WIDTH  load value.
- sat  in  1  boundary mode: 0 = wrap, 1 = saturate.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational).
- ovf  out  1  one-cycle overflow/underflow pulse (registered).

Behaviour:
- Reset: one clock ck; reset res is asynchronous, active-low. While res=0: q=0, prescaler count=0, ovf=0. tc then follows its equation, giving up=1 -> 0 and up=0 -> 1.
- All state updates occur on the rising edge of ck while res=1.
- tick:
  - tick = en AND (prescaler count == PRESCALE-1).
  - The prescaler counts 0..PRESCALE-1 on each cycle where en=1, wraps to 0 on tick, and holds when en=0.
  - With PRESCALE=1, tick = en.
- Priority, highest first: res, then ld, then tick, then hold.
- Load (ld=1):
  - q <= d, or q <= MODULUS-1 if d >= MODULUS (clamp).
  - Prescaler count <= 0. ovf <= 0.
  - ld overrides a simultaneous tick, and the tick is lost.
- tick with up=1:
  - If q < MODULUS-1: q <= q+1, ovf <= 0.
  - If q == MODULUS-1 and sat=0: q <= 0, ovf <= 1.
  - If q == MODULUS-1 and sat=1: q holds, ovf <= 1.
- tick with up=0:
  - If q > 0: q <= q-1, ovf <= 0.
  - If q == 0 and sat=0: q <= MODULUS-1, ovf <= 1.
  - If q == 0 and sat=1: q holds, ovf <= 1.
- No tick and no ld: q holds, ovf <= 0. ovf is therefore never high for two cycles unless a boundary tick occurs on consecutive cycles.
- tc = (up AND q==MODULUS-1) OR (NOT up AND q==0). tc is independent of en and sat.
- Cascade rule: the next stage's en = this stage's tc AND this stage's tick condition. Expose tick internally only; cascading at the top level uses en_next = en AND tc when PRESCALE=1.
- Changing up mid-count takes effect on the next tick, with no extra latency. tc changes combinationally with up.
- Changing sat or MODULUS boundary behaviour never alters q without a tick or ld.
- Reset mid-count: q and ovf clear immediately (asynchronously). The first tick after release is a full PRESCALE periods later.
- Width rule: internal compares use WIDTH bits. MODULUS-1 is computed at elaboration, and there are no arithmetic carries beyond WIDTH.

Decomposition:
- Shared package counter_pkg holds:
  - a direction constant (CNT_UP=1, CNT_DOWN=0),
  - a mode constant (MODE_WRAP=0, MODE_SAT=1),
  - a function clog2 used to size the prescaler register.
- One natural sub-module: counter_prescaler (ports ck, res, en, clr, tick; parameter PRESCALE). clr is driven by ld. The sub-module is generated as a pass-through (tick = en) when PRESCALE=1.
- Elaboration-time check: report a fatal error if MODULUS is outside 2..2**WIDTH or PRESCALE < 1.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1: hold res=0 for 1 cycle, release, then en=1, up=1, sat=0 for 12 cycles -> q = 1,2,...,9,0,1,2. tc is high only while q=9. ovf is high for exactly the cycle q becomes 0.
- Same config, up=0 from q=0 -> q = 9,8,7. ovf pulses on the 0->9 transition. tc is high while q=0.
- sat=1, up=1, count to 9 and apply 3 more ticks -> q stays 9, ovf high on each of those 3 cycles. Switch up=0 -> the next tick gives q=8.
- ld=1 with d=4 and en=1 on the same cycle -> q=4 next cycle, no increment. ld with d=13 -> q=9 (clamp).
- PRESCALE=3, en=1 continuously -> q advances every 3rd clock. Drop en for 2 cycles mid-period -> the step is delayed by exactly 2 clocks.
- Assert res=0 mid-cycle while q=7, away from a ck edge -> q=0 and ovf=0 immediately. Two cascaded instances (units tc feeding tens en) count 00->99->00, with ovf of the tens stage pulsing once at the wrap.
